stump_control_ws: RTL and testbench

Wait-state-aware, parametrised successor to the Stump control unit. Combines the instruction-cycle FSM and instruction decode. Adds a `mem_ready` handshake so fetch and memory cycles can stretch over slow memory, and a configurable bus timeout that parks the processor in an error state. Sits between the Stump datapath (`ir`, `cc`) and the memory interface; its control outputs drive the register bank, ALU, shifter and memory strobes.

---
 rtl/stump_control_ws.sv | 200 ++++++++++++++++++++
 tb/tb_stump_control_ws.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stump_control_ws.sv
// Stump control unit with memory wait states and a bus timeout.
// Instruction-cycle FSM plus decode; outputs are combinational.
module stump_control_ws #(
  parameter int TIMEOUT = 15,
  parameter int WAIT_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cc,
  input  logic [15:0] ir,
  input  logic        mem_ready,
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic        ext_op,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [1:0]  shift_op,
  output logic        opB_mux_sel,
  output logic [2:0]  alu_func,
  output logic        cc_en,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic        stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;

  logic [2:0] op;
  logic       is_alu, is_mem, is_bcc;
  logic       n, z, v, c;
  logic       base, cond;
  logic       tmo;
  logic       stl;
  logic       rw, cen, ren, wen;

  assign op     = ir[15:13];
  assign is_alu = (op <= 3'd5);
  assign is_mem = (op == 3'd6);
  assign is_bcc = (op == 3'd7);
  assign {n, z, v, c} = cc;

  assign tmo = (TIMEOUT != 0) &&
               (wait_q == WAIT_W'(TIMEOUT));

  // Branch condition: odd codes invert the even one below.
  always_comb begin
    base = 1'b1;
    case (ir[11:9])
      3'd0: base = 1'b1;
      3'd1: base = ~c & ~z;
      3'd2: base = ~c;
      3'd3: base = ~z;
      3'd4: base = ~v;
      3'd5: base = ~n;
      3'd6: base = (n == v);
      3'd7: base = ~z & (n == v);
    endcase
    cond = base ^ ir[8];
  end

  // State, wait counter and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state; a stalled access past the limit parks in ERROR.
  always_comb begin
    state_d = state_q;
    stl     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_EXEC;
        end else begin
          stl = 1'b1;
          if (tmo) state_d = S_ERR;
        end
      end
      S_EXEC: begin
        state_d = is_mem ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          stl = 1'b1;
          if (tmo) state_d = S_ERR;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
    endcase

    if (state_d != state_q || mem_ready) begin
      wait_d = '0;
    end else if (stl) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end

    bus_err_d = bus_err_q | (state_d == S_ERR);
  end

  // Datapath control decode for the current state.
  always_comb begin
    ext_op      = 1'b0;
    rw          = 1'b0;
    dest        = 3'd0;
    srcA        = 3'd0;
    srcB        = 3'd0;
    shift_op    = 2'b00;
    opB_mux_sel = 1'b0;
    alu_func    = 3'b000;
    cen         = 1'b0;
    ren         = 1'b0;
    wen         = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ren         = 1'b1;
        dest        = 3'd7;
        srcA        = 3'd7;
        opB_mux_sel = 1'b1;
        rw          = mem_ready;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu: begin
            alu_func    = op;
            rw          = 1'b1;
            dest        = ir[10:8];
            srcA        = ir[7:5];
            srcB        = ir[4:2];
            opB_mux_sel = ir[12];
            shift_op    = ir[12] ? 2'b00 : ir[1:0];
            cen         = ir[11];
          end
          is_mem: begin
            srcA        = ir[7:5];
            srcB        = ir[4:2];
            opB_mux_sel = ir[12];
            shift_op    = ir[12] ? 2'b00 : ir[1:0];
          end
          is_bcc: begin
            ext_op      = 1'b1;
            opB_mux_sel = 1'b1;
            dest        = 3'd7;
            srcA        = 3'd7;
            rw          = cond;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (ir[11]) begin
          ren  = 1'b1;
          rw   = mem_ready;
          dest = ir[10:8];
        end else begin
          wen  = 1'b1;
          srcA = ir[10:8];
        end
      end
      S_ERR: ;
    endcase
  end

  assign fetch     = (state_q == S_FETCH);
  assign execute   = (state_q == S_EXEC);
  assign memory    = (state_q == S_MEM);
  assign stall     = stl & rst;
  assign reg_write = rw & rst;
  assign cc_en     = cen & rst;
  assign mem_ren   = ren & rst;
  assign mem_wen   = wen & rst;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_stump_control_ws.sv
// Bench for stump_control_ws (TIMEOUT=3).
// Expected control vectors queue up as stimulus is applied.
module tb_stump_control_ws;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cc = '0;
  logic [15:0] ir = '0;
  logic        mem_ready = 1'b0;
  logic        fetch, execute, memory, ext_op, reg_write;
  logic [2:0]  dest, srcA, srcB, alu_func;
  logic [1:0]  shift_op;
  logic        opB_mux_sel, cc_en, mem_ren, mem_wen;
  logic        stall, bus_err;

  int errs = 0;
  int checks = 0;
  logic [9:0] sb[$];

  // {fetch,execute,memory,bus_err,stall,
  //  reg_write,cc_en,ext_op,mem_ren,mem_wen}
  localparam logic [9:0] V_RST = 10'b1000000000;
  localparam logic [9:0] V_FR  = 10'b1000010010;
  localparam logic [9:0] V_FS  = 10'b1000100010;
  localparam logic [9:0] V_XAC = 10'b0100011000;
  localparam logic [9:0] V_XA  = 10'b0100010000;
  localparam logic [9:0] V_XM  = 10'b0100000000;
  localparam logic [9:0] V_BT  = 10'b0100010100;
  localparam logic [9:0] V_BN  = 10'b0100000100;
  localparam logic [9:0] V_LDS = 10'b0010100010;
  localparam logic [9:0] V_LDR = 10'b0010010010;
  localparam logic [9:0] V_STS = 10'b0010100001;
  localparam logic [9:0] V_ERR = 10'b0001000000;

  typedef struct {
    logic [15:0] i;
    logic [3:0]  c;
    logic        tk;
  } br_t;

  br_t bt[7] = '{
    '{16'hE7F0, 4'b0100, 1'b1},
    '{16'hE7F0, 4'b0000, 1'b0},
    '{16'hE1F0, 4'b0100, 1'b0},
    '{16'hE1F0, 4'b0000, 1'b0},
    '{16'hEE00, 4'b1010, 1'b1},
    '{16'hEF00, 4'b1010, 1'b0},
    '{16'hE200, 4'b0000, 1'b1}
  };

  always #5 clk = ~clk;

  stump_control_ws #(
    .TIMEOUT(3),
    .WAIT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cc         (cc),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .fetch      (fetch),
    .execute    (execute),
    .memory     (memory),
    .ext_op     (ext_op),
    .reg_write  (reg_write),
    .dest       (dest),
    .srcA       (srcA),
    .srcB       (srcB),
    .shift_op   (shift_op),
    .opB_mux_sel(opB_mux_sel),
    .alu_func   (alu_func),
    .cc_en      (cc_en),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .stall      (stall),
    .bus_err    (bus_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctl();
    return {fetch, execute, memory, bus_err, stall,
            reg_write, cc_en, ext_op, mem_ren, mem_wen};
  endfunction

  task automatic step(input string tag,
                      input logic [15:0] i,
                      input logic [3:0] c,
                      input logic r,
                      input logic [9:0] e);
    logic [9:0] x;
    ir = i;
    cc = c;
    mem_ready = r;
    sb.push_back(e);
    #3;
    x = sb.pop_front();
    check(tag, 32'(ctl()), 32'(x));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag,
                     input logic [15:0] i,
                     input logic [3:0] c,
                     input logic r,
                     input logic [9:0] e);
    step(tag, i, c, r, e);
    tick();
  endtask

  initial begin
    #2 rst = 1'b0;
    tick();
    cyc("rst_nrdy", 16'h0000, 4'h0, 1'b0, V_RST);
    step("rst_rdy", 16'h0000, 4'h0, 1'b1, V_RST);
    tick();
    rst = 1'b1;

    // ADD R2,R2,R1 with flag update
    cyc("add_f", 16'h0A44, 4'h0, 1'b1, V_FR);
    step("add_x", 16'h0A44, 4'h0, 1'b1, V_XAC);
    check("add_dest", 32'(dest), 32'd2);
    check("add_srcA", 32'(srcA), 32'd2);
    check("add_srcB", 32'(srcB), 32'd1);
    check("add_alu", 32'(alu_func), 32'd0);
    check("add_opb", 32'(opB_mux_sel), 32'd0);
    tick();

    // register form with a shift
    cyc("sh_f", 16'h0A46, 4'h0, 1'b1, V_FR);
    step("sh_x", 16'h0A46, 4'h0, 1'b0, V_XAC);
    check("sh_op", 32'(shift_op), 32'd2);
    tick();

    // SUB immediate, shift bits ignored
    cyc("sub_f", 16'h539F, 4'h0, 1'b1, V_FR);
    step("sub_x", 16'h539F, 4'h0, 1'b1, V_XA);
    check("sub_alu", 32'(alu_func), 32'd2);
    check("sub_opb", 32'(opB_mux_sel), 32'd1);
    check("sub_sh", 32'(shift_op), 32'd0);
    check("sub_dest", 32'(dest), 32'd3);
    check("sub_srcA", 32'(srcA), 32'd4);
    tick();

    // LD R5,[R1,R2] with two wait states
    cyc("ld_f", 16'hCD28, 4'h0, 1'b1, V_FR);
    step("ld_x", 16'hCD28, 4'h0, 1'b0, V_XM);
    check("ld_alu", 32'(alu_func), 32'd0);
    check("ld_srcA", 32'(srcA), 32'd1);
    check("ld_srcB", 32'(srcB), 32'd2);
    tick();
    cyc("ld_w1", 16'hCD28, 4'h0, 1'b0, V_LDS);
    cyc("ld_w2", 16'hCD28, 4'h0, 1'b0, V_LDS);
    step("ld_m", 16'hCD28, 4'h0, 1'b1, V_LDR);
    check("ld_dest", 32'(dest), 32'd5);
    tick();

    // conditional branches
    foreach (bt[k]) begin
      cyc("br_f", bt[k].i, bt[k].c, 1'b1, V_FR);
      step($sformatf("br%0d", k), bt[k].i, bt[k].c,
           1'b1, bt[k].tk ? V_BT : V_BN);
      check("br_dest", 32'(dest), 32'd7);
      check("br_srcA", 32'(srcA), 32'd7);
      tick();
    end

    // timeout in FETCH
    for (int k = 0; k < 4; k++) begin
      cyc("to_stall", 16'h0A44, 4'h0, 1'b0, V_FS);
    end
    cyc("to_err0", 16'h0A44, 4'h0, 1'b0, V_ERR);
    cyc("to_err1", 16'h0A44, 4'h0, 1'b1, V_ERR);
    step("to_err2", 16'h0A44, 4'h0, 1'b1, V_ERR);
    rst = 1'b0;
    step("to_rst", 16'h0A44, 4'h0, 1'b1, V_RST);
    tick();
    rst = 1'b1;

    // ready arrives exactly at the limit
    for (int k = 0; k < 3; k++) begin
      cyc("lim_stall", 16'h0A44, 4'h0, 1'b0, V_FS);
    end
    cyc("lim_rdy", 16'h0A44, 4'h0, 1'b1, V_FR);
    cyc("lim_x", 16'h0A44, 4'h0, 1'b0, V_XAC);

    // ST R3 interrupted by reset in MEMORY
    cyc("st_f", 16'hC344, 4'h0, 1'b1, V_FR);
    cyc("st_x", 16'hC344, 4'h0, 1'b1, V_XM);
    step("st_w", 16'hC344, 4'h0, 1'b0, V_STS);
    check("st_srcA", 32'(srcA), 32'd3);
    rst = 1'b0;
    step("st_rst", 16'hC344, 4'h0, 1'b0, V_RST);
    tick();
    rst = 1'b1;
    cyc("st_refetch", 16'h0A44, 4'h0, 1'b1, V_FR);
    cyc("st_rex", 16'h0A44, 4'h0, 1'b1, V_XAC);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
